// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall control block.
package hazard_pkg;

  localparam int unsigned RF_ADDR_W_DFLT = 5;
  localparam int unsigned CNT_W_DFLT     = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } hz_state_t;

  // Hazard causes, lowest index wins when several are active.
  localparam int unsigned PRIO_HALT    = 0;
  localparam int unsigned PRIO_MEM     = 1;
  localparam int unsigned PRIO_MISPRED = 2;
  localparam int unsigned PRIO_LOADUSE = 3;
  localparam int unsigned PRIO_IMISS   = 4;
  localparam int unsigned PRIO_NONE    = 5;
  localparam int unsigned N_PRIO       = 6;
  localparam int unsigned PRIO_W       = 3;

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush control for the 5-stage pipeline: load-use, D-mem wait,
// mispredict redirect, I-fetch miss and halt, plus stall/flush counters.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DFLT,
  parameter int unsigned RF_ADDR_W = RF_ADDR_W_DFLT
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [RF_ADDR_W-1:0] id_rs1,
  input  logic [RF_ADDR_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [RF_ADDR_W-1:0] idex_rd,
  input  logic                 idex_regwrite,
  input  logic                 idex_memtoreg,
  input  logic                 exmem_dmemren,
  input  logic                 exmem_dmemwen,
  input  logic                 dhit,
  input  logic                 ihit,
  input  logic                 ex_mispredict,
  input  logic                 memwb_halt,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 idex_en,
  output logic                 exmem_en,
  output logic                 memwb_en,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 exmem_flush,
  output logic                 memwb_flush,
  output logic                 halted,
  output logic [CNT_W-1:0]     lu_stall_cnt,
  output logic [CNT_W-1:0]     mem_stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  hz_state_t         state;
  logic              mem_op;
  logic              mem_wait;
  logic              load_use;
  logic [N_PRIO-1:0] hz_vec;
  logic [PRIO_W-1:0] win;

  // A mem op that completes on dhit this cycle costs nothing; x0 never hazards.
  always_comb begin
    mem_op   = exmem_dmemren | exmem_dmemwen;
    mem_wait = !dhit && ((state == DWAIT) || mem_op);
    load_use = idex_memtoreg && idex_regwrite && (idex_rd != '0) &&
               ((id_uses_rs1 && (id_rs1 == idex_rd)) ||
                (id_uses_rs2 && (id_rs2 == idex_rd)));

    hz_vec               = '0;
    hz_vec[PRIO_HALT]    = (state == HALT);
    hz_vec[PRIO_MEM]     = mem_wait;
    hz_vec[PRIO_MISPRED] = ex_mispredict;
    hz_vec[PRIO_LOADUSE] = load_use;
    hz_vec[PRIO_IMISS]   = !ihit;
    hz_vec[PRIO_NONE]    = 1'b1;

    win = PRIO_W'(PRIO_NONE);
    for (int i = int'(N_PRIO) - 1; i >= 0; i--) begin
      if (hz_vec[i]) win = PRIO_W'(i);
    end
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    case (win)
      PRIO_W'(PRIO_HALT): begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end
      PRIO_W'(PRIO_MEM): begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_flush = 1'b1;
      end
      PRIO_W'(PRIO_MISPRED): begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      PRIO_W'(PRIO_LOADUSE): begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
      PRIO_W'(PRIO_IMISS): begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
      default: ;
    endcase

    // A bubble only lands if the latch is clocked.
    ifid_en  = ifid_en  | ifid_flush;
    idex_en  = idex_en  | idex_flush;
    exmem_en = exmem_en | exmem_flush;
    memwb_en = memwb_en | memwb_flush;

    if (!nRST) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
      {ifid_flush, idex_flush, exmem_flush, memwb_flush} = '1;
    end
  end

  // Halt is taken only when the halting instruction actually retires.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= RUN;
      halted <= 1'b0;
    end else if ((state != HALT) && memwb_halt && memwb_en) begin
      state  <= HALT;
      halted <= 1'b1;
    end else begin
      case (state)
        RUN:     if (mem_op && !dhit) state <= DWAIT;
        DWAIT:   if (dhit) state <= RUN;
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .inc   (win == PRIO_W'(PRIO_LOADUSE)),
    .clear (1'b0),
    .count (lu_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mem_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .inc   (win == PRIO_W'(PRIO_MEM)),
    .clear (1'b0),
    .count (mem_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .inc   (win == PRIO_W'(PRIO_MISPRED)),
    .clear (1'b0),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Randomized and directed bench for hazard_stall_unit against a rule-level model.
module tb_hazard_stall_unit;

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int          CMAX      = (1 << CNT_W) - 1;

  logic                 CLK = 1'b0;
  logic                 nRST;
  logic [RF_ADDR_W-1:0] id_rs1, id_rs2, idex_rd;
  logic                 id_uses_rs1, id_uses_rs2, idex_regwrite, idex_memtoreg;
  logic                 exmem_dmemren, exmem_dmemwen, dhit, ihit, ex_mispredict, memwb_halt;
  logic                 pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic                 ifid_flush, idex_flush, exmem_flush, memwb_flush, halted;
  logic [CNT_W-1:0]     lu_stall_cnt, mem_stall_cnt, flush_cnt;
  logic [8:0]           ctl_vec;

  int checks = 0;
  int errors = 0;

  bit m_halt, m_wait;
  int m_lu, m_mem, m_fl;

  always #5 CLK = ~CLK;

  assign ctl_vec = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_flush, idex_flush, exmem_flush, memwb_flush};

  hazard_stall_unit #(.CNT_W(CNT_W), .RF_ADDR_W(RF_ADDR_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .idex_rd(idex_rd), .idex_regwrite(idex_regwrite), .idex_memtoreg(idex_memtoreg),
    .exmem_dmemren(exmem_dmemren), .exmem_dmemwen(exmem_dmemwen), .dhit(dhit),
    .ihit(ihit), .ex_mispredict(ex_mispredict), .memwb_halt(memwb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halted(halted),
    .lu_stall_cnt(lu_stall_cnt), .mem_stall_cnt(mem_stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    id_rs1 = '0; id_rs2 = '0; idex_rd = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; idex_regwrite = 0; idex_memtoreg = 0;
    exmem_dmemren = 0; exmem_dmemwen = 0; dhit = 0; ihit = 1;
    ex_mispredict = 0; memwb_halt = 0;
  endtask

  task automatic model_reset();
    m_halt = 0; m_wait = 0; m_lu = 0; m_mem = 0; m_fl = 0;
  endtask

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  // Inputs are already driven (just after negedge); check, advance model, move to next negedge.
  task automatic step();
    logic [8:0] e;
    bit memw, lu;
    #1;
    memw = (m_wait || exmem_dmemren || exmem_dmemwen) && !dhit;
    lu   = idex_memtoreg && idex_regwrite && (idex_rd != 0) &&
           ((id_uses_rs1 && id_rs1 == idex_rd) || (id_uses_rs2 && id_rs2 == idex_rd));
    if (m_halt)             e = 9'b00000_0000;
    else if (memw)          e = 9'b00001_0001;
    else if (ex_mispredict) e = 9'b11111_1100;
    else if (lu)            e = 9'b00111_0100;
    else if (!ihit)         e = 9'b01111_1000;
    else                    e = 9'b11111_0000;
    check_eq("ctl", 32'(ctl_vec), 32'(e));
    check_eq("halted", 32'(halted), 32'(m_halt));
    check_eq("lu_cnt", 32'(lu_stall_cnt), 32'(m_lu));
    check_eq("mem_cnt", 32'(mem_stall_cnt), 32'(m_mem));
    check_eq("flush_cnt", 32'(flush_cnt), 32'(m_fl));
    if (!m_halt) begin
      if (memw)               m_mem = sat_inc(m_mem);
      else if (ex_mispredict) m_fl  = sat_inc(m_fl);
      else if (lu)            m_lu  = sat_inc(m_lu);
      if (memwb_halt && e[4]) m_halt = 1;
      else                    m_wait = memw;
    end
    @(negedge CLK);
  endtask

  task automatic rand_inputs();
    id_rs1        = RF_ADDR_W'($urandom_range(0, 3));
    id_rs2        = RF_ADDR_W'($urandom_range(0, 3));
    idex_rd       = RF_ADDR_W'($urandom_range(0, 3));
    id_uses_rs1   = 1'($urandom_range(0, 1));
    id_uses_rs2   = 1'($urandom_range(0, 1));
    idex_regwrite = ($urandom_range(0, 3) != 0);
    idex_memtoreg = ($urandom_range(0, 1) != 0);
    exmem_dmemren = ($urandom_range(0, 5) == 0);
    exmem_dmemwen = ($urandom_range(0, 7) == 0);
    dhit          = ($urandom_range(0, 2) == 0);
    ihit          = ($urandom_range(0, 4) != 0);
    ex_mispredict = ($urandom_range(0, 7) == 0);
    memwb_halt    = 0;
  endtask

  initial begin
    set_idle();
    model_reset();
    nRST = 0;
    #2;
    check_eq("rst_ctl", 32'(ctl_vec), 32'h00F);
    check_eq("rst_halted", 32'(halted), 32'd0);
    @(negedge CLK);
    nRST = 1;

    // Load-use on x5, then the bubble clears it.
    idex_rd = 5; idex_memtoreg = 1; idex_regwrite = 1; id_rs1 = 5; id_uses_rs1 = 1;
    step();
    set_idle();
    step();
    check_eq("lu_once", 32'(lu_stall_cnt), 32'd1);

    // Load into x0 never stalls.
    idex_rd = 0; idex_memtoreg = 1; idex_regwrite = 1; id_rs1 = 0; id_uses_rs1 = 1;
    step();
    set_idle();

    // Store waiting four cycles for dhit.
    exmem_dmemwen = 1;
    for (int i = 0; i < 4; i++) step();
    dhit = 1;
    step();
    set_idle();
    step();
    check_eq("store_wait", 32'(mem_stall_cnt), 32'd4);

    // Mispredict together with load-use.
    idex_rd = 7; idex_memtoreg = 1; idex_regwrite = 1; id_rs2 = 7; id_uses_rs2 = 1;
    ex_mispredict = 1;
    step();
    set_idle();
    check_eq("mis_lu_flush", 32'(flush_cnt), 32'd1);
    check_eq("mis_lu_lu", 32'(lu_stall_cnt), 32'd1);

    // Mispredict held across a three-cycle load wait.
    exmem_dmemren = 1; ex_mispredict = 1;
    for (int i = 0; i < 3; i++) step();
    check_eq("mis_held", 32'(flush_cnt), 32'd1);
    dhit = 1;
    step();
    set_idle();
    step();
    check_eq("mis_after", 32'(flush_cnt), 32'd2);

    // Random traffic, long enough to saturate the narrow counters.
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      step();
    end

    // Halt retires, then everything stays frozen.
    set_idle();
    memwb_halt = 1;
    step();
    memwb_halt = 0;
    for (int i = 0; i < 10; i++) begin
      rand_inputs();
      step();
    end
    check_eq("halt_sticky", 32'(halted), 32'd1);

    // Asynchronous reset mid-cycle.
    #2 nRST = 0;
    #1;
    model_reset();
    check_eq("arst_halted", 32'(halted), 32'd0);
    check_eq("arst_cnt", 32'({lu_stall_cnt, mem_stall_cnt, flush_cnt}), 32'd0);
    check_eq("arst_ctl", 32'(ctl_vec), 32'h00F);
    @(negedge CLK);
    nRST = 1;
    for (int i = 0; i < 50; i++) begin
      rand_inputs();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
